r2r_adc_controller: RTL and testbench
=====================================

# r2r_adc_controller

Conversion engine for the R2R-ladder ADC path. It drives the 8-bit R2R DAC and samples the external comparator. Conversions run by successive approximation or by a linear ramp, chosen per conversion. Each completed code is handed downstream (averaging/scaling/7-segment path) with a one-cycle `ready` strobe. The block sits between the board pins (`R2R_out`, `comp_r2r`) and the top-level data path.

## Interface
- `SETTLE_CYCLES`, default 6250: clock cycles per DAC step (62.5 µs at 100 MHz); legal range ≥ 4.
- `WIDTH`, default 8: DAC/result width in bits.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; high = convert continuously, low = idle.
- `algorithm_sel`  in  1  0 = successive approximation (SAR), 1 = ramp; sampled only at conversion start.
- `comp_in`  in  1  asynchronous comparator output; 1 = analog input ≥ DAC voltage.
- `r2r_out`  out  WIDTH  DAC code driven to the ladder.
- `sample_out`  out  WIDTH  last completed conversion result, held.
- `ready`  out  1  one-cycle strobe; `sample_out` is new in this cycle.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- **Comparator input:** `comp_in` passes through a 2-FF synchronizer. All decisions use the synchronized value `comp_s`.
- **States:** IDLE, CONVERT, DONE.
- **IDLE**
  - `r2r_out`=0, `busy`=0.
  - If `enable`=1, latch `algorithm_sel` into `mode` and go to CONVERT.
- **CONVERT, step timing**
  - A step counter runs 0..SETTLE_CYCLES−1.
  - The decision is made in the cycle where counter = SETTLE_CYCLES−1.
  - The new `r2r_out` appears on the following edge.
- **SAR mode (`mode`=0)**
  - Entry: `trial`=1000…0 (MSB set); `r2r_out`=`trial`.
  - Each decision: if `comp_s`=0, clear the current bit. Then set the next lower bit.
  - After the LSB decision, go to DONE with `result`=`trial`.
  - Fixed length: WIDTH steps.
- **Ramp mode (`mode`=1)**
  - Entry: `code`=0.
  - Each decision where `comp_s`=1 and `code`<2^WIDTH−1: `code`+1.
  - Decision with `comp_s`=0: `result`=`code`−1, or 0 if `code`=0; go to DONE.
  - Decision with `comp_s`=1 at `code`=2^WIDTH−1: `result`=2^WIDTH−1; go to DONE (saturate, no wrap).
- **DONE** (exactly one cycle)
  - `sample_out`←`result`, `ready`=1, `r2r_out` holds its last value.
  - Next state is CONVERT (re-latching `algorithm_sel`) if `enable`=1, else IDLE.
- **`enable` falls during CONVERT:** abort on the next edge and go to IDLE.
  - `r2r_out`→0, no `ready`, `sample_out` unchanged.
- **`algorithm_sel` change mid-conversion:** ignored until the next conversion start.
- **Reset (at any time, including mid-conversion):** IDLE; `r2r_out`=0, `sample_out`=0, `ready`=0, `busy`=0; synchronizer and counters cleared.

## Timing
- The registered-input cycle when `enable` is seen high is cycle 0. `r2r_out` holds the first trial code from cycle 1.
- SAR conversion: `ready` appears WIDTH·SETTLE_CYCLES + 1 cycles after CONVERT entry.
- Back-to-back period:
  - SAR: WIDTH·SETTLE_CYCLES + 1 cycles.
  - Ramp: (steps taken)·SETTLE_CYCLES + 1 cycles.
- Comparator-to-decision latency: 2 cycles (synchronizer). `comp_in` must be stable during the last 3 cycles of each step.
- `busy`: high in CONVERT, low in IDLE and DONE.
- `ready` is never asserted on two consecutive cycles.
- All outputs are registered.

## Test plan
- **Reset mid-conversion:** SETTLE_CYCLES=16, SAR running, pulse `reset` at step 3 → all outputs 0 on the same edge; a new conversion starts 1 cycle after release with `enable`=1.
- **SAR scripted comparator:** drive `comp_in` per step as 1,1,0,1,1,0,1,0 →
  - `r2r_out` sequence 0x80, 0xC0, 0xE0, 0xD0, 0xD8, 0xDC, 0xDA, 0xDB;
  - `sample_out`=0xDA with `ready` for one cycle, 129 cycles after CONVERT entry.
- **Analog model, vin=0x5A:** `comp_in`=(vin ≥ `r2r_out`) → SAR gives 0x5A; ramp gives 0x5A after 92 steps.
- **Extremes:**
  - vin=0xFF: SAR 0xFF; ramp 0xFF after 256 steps, no wrap.
  - `comp_in` stuck 0: both modes give 0x00 (ramp after 1 step).
- **Mode and enable handling:**
  - Toggle `algorithm_sel` mid-SAR → current result still SAR (0xDA); the next conversion uses ramp.
  - Drop `enable` mid-conversion → no `ready`, `r2r_out`=0 next cycle, `sample_out` retains the prior value.
- **Continuous mode:** 5 SAR conversions with a constant vin → `ready` pulses exactly 129 cycles apart; `busy` is low only in the DONE cycles.

Source files
------------

// File: rtl/r2r_adc_controller_if.sv
// Signal bundle between the R2R ADC conversion engine and its surroundings:
// control inputs, comparator pin, DAC code and the downstream result strobe.
interface r2r_adc_controller_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             algorithm_sel;
    logic             comp_in;
    logic [WIDTH-1:0] r2r_out;
    logic [WIDTH-1:0] sample_out;
    logic             ready;
    logic             busy;

    // master: the environment driving the controller; slave: the controller itself
    modport master (
        output enable, algorithm_sel, comp_in,
        input  r2r_out, sample_out, ready, busy
    );

    modport slave (
        input  enable, algorithm_sel, comp_in,
        output r2r_out, sample_out, ready, busy
    );
endinterface

// File: rtl/r2r_adc_controller.sv
// R2R-ladder ADC conversion engine: SAR or linear-ramp search on an 8-bit DAC
// against a synchronized comparator, with a one-cycle ready strobe per result.
module r2r_adc_controller #(
    parameter int unsigned SETTLE_CYCLES = 6250,
    parameter int unsigned WIDTH         = 8
) (
    input logic                 clk,
    input logic                 reset,
    r2r_adc_controller_if.slave bus
);
    localparam int unsigned      CntW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MsbHot  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             mode_q, mode_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [1:0]       sync_q;
    logic             comp_s;
    logic [WIDTH-1:0] trial;

    assign comp_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            code_q   <= '0;
            bit_q    <= '0;
            result_q <= '0;
            sample_q <= '0;
            mode_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            bit_q    <= bit_d;
            result_q <= result_d;
            sample_q <= sample_d;
            mode_q   <= mode_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            sync_q   <= {sync_q[0], bus.comp_in};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        bit_d    = bit_q;
        result_d = result_q;
        sample_d = sample_q;
        mode_d   = mode_q;
        ready_d  = 1'b0;
        busy_d   = busy_q;
        trial    = code_q;

        unique case (state_q)
            StIdle: begin
                code_d = '0;
                busy_d = 1'b0;
            end
            StConvert: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    code_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    cnt_d = '0;
                    if (!mode_q) begin
                        if (!comp_s) trial = code_q & ~bit_q;
                        if (bit_q[0]) begin
                            // code_q stays put so the ladder holds through DONE
                            result_d = trial;
                            state_d  = StDone;
                            busy_d   = 1'b0;
                        end else begin
                            code_d = trial | (bit_q >> 1);
                            bit_d  = bit_q >> 1;
                        end
                    end else if (comp_s && code_q != '1) begin
                        code_d = code_q + WIDTH'(1);
                    end else begin
                        if (comp_s) result_d = '1;
                        else        result_d = (code_q == '0) ? '0 : code_q - WIDTH'(1);
                        state_d = StDone;
                        busy_d  = 1'b0;
                    end
                end
            end
            StDone: begin
                sample_d = result_q;
                ready_d  = 1'b1;
                state_d  = StIdle;
                code_d   = '0;
                busy_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Conversion start, shared by IDLE and the back-to-back path out of DONE
        if (bus.enable && state_q != StConvert) begin
            state_d = StConvert;
            mode_d  = bus.algorithm_sel;
            cnt_d   = '0;
            bit_d   = MsbHot;
            code_d  = bus.algorithm_sel ? '0 : MsbHot;
            busy_d  = 1'b1;
        end
    end

    assign bus.r2r_out    = code_q;
    assign bus.sample_out = sample_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_r2r_adc_controller.sv
// Directed bench for r2r_adc_controller with SETTLE_CYCLES=16: scripted and
// modelled comparator, both algorithms, extremes, aborts, reset and streaming.
module tb_r2r_adc_controller;
    localparam int unsigned S = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic analog = 1'b0;
    logic comp_force = 1'b0;
    logic [7:0] vin = 8'h00;
    int checks = 0;
    int errors = 0;

    logic [7:0] sar_cmp [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] sar_exp [8] = '{8'h80, 8'hC0, 8'hE0, 8'hD0, 8'hD8, 8'hDC, 8'hDA, 8'hDB};

    r2r_adc_controller_if #(.WIDTH(8)) bus ();

    r2r_adc_controller #(.SETTLE_CYCLES(S), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Comparator: either a forced level or an ideal analog compare against the DAC
    assign bus.comp_in = analog ? (vin >= bus.r2r_out) : comp_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Ticks until ready is seen; cyc counts ticks, prev is r2r_out in the tick before ready
    task automatic wait_ready(input string tag, input int budget, output int cyc,
                              output logic [7:0] res, output logic [7:0] prev, output int nlo);
        logic [7:0] last;
        cyc = 0; nlo = 0; res = '0; prev = '0;
        while (cyc < budget) begin
            last = bus.r2r_out;
            tick();
            cyc++;
            if (!bus.busy) nlo++;
            if (bus.ready) begin
                res = bus.sample_out;
                prev = last;
                return;
            end
        end
        checks++;
        errors++;
        $error("FAIL %s timeout observed=no_ready expected=ready within %0d cycles", tag, budget);
        cyc = -1;
    endtask

    // Starts a conversion from idle; cyc is returned relative to the CONVERT entry edge
    task automatic run_conv(input string tag, input logic alg, input int budget,
                            output int cyc, output logic [7:0] res, output logic [7:0] prev);
        int nlo;
        bus.enable = 1'b1;
        bus.algorithm_sel = alg;
        wait_ready(tag, budget, cyc, res, prev, nlo);
        if (cyc > 0) cyc--;
    endtask

    task automatic stop();
        bus.enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int cyc, nlo;
        logic [7:0] res, prev;
        bit seen;

        bus.enable = 1'b0;
        bus.algorithm_sel = 1'b0;
        tick();
        tick();
        check("rst_r2r", 32'(bus.r2r_out), 32'h0);
        check("rst_sample", 32'(bus.sample_out), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'h0);

        // SAR with scripted comparator 1,1,0,1,1,0,1,0
        bus.enable = 1'b1;
        bus.algorithm_sel = 1'b0;
        comp_force = sar_cmp[0][0];
        tick();
        check("sar_busy", 32'(bus.busy), 32'h1);
        for (int k = 0; k < 8; k++) begin
            comp_force = sar_cmp[k][0];
            check($sformatf("sar_step%0d", k), 32'(bus.r2r_out), 32'(sar_exp[k]));
            repeat (S) tick();
        end
        check("sar_done_busy", 32'(bus.busy), 32'h0);
        check("sar_done_noready", 32'(bus.ready), 32'h0);
        check("sar_done_hold", 32'(bus.r2r_out), 32'hDB);
        bus.enable = 1'b0;
        tick();
        check("sar_ready_129", 32'(bus.ready), 32'h1);
        check("sar_result", 32'(bus.sample_out), 32'hDA);
        check("sar_idle_r2r", 32'(bus.r2r_out), 32'h0);
        tick();
        check("sar_ready_once", 32'(bus.ready), 32'h0);
        check("sar_sample_hold", 32'(bus.sample_out), 32'hDA);

        // Analog model vin=0x5A
        analog = 1'b1;
        vin = 8'h5A;
        run_conv("sar_5a", 1'b0, 400, cyc, res, prev);
        check("sar_5a_res", 32'(res), 32'h5A);
        check("sar_5a_cyc", 32'(cyc), 32'd129);
        stop();
        run_conv("ramp_5a", 1'b1, 3000, cyc, res, prev);
        check("ramp_5a_res", 32'(res), 32'h5A);
        check("ramp_5a_cyc", 32'(cyc), 32'(92 * S + 1));
        stop();

        // Full-scale input: saturate, no wrap
        vin = 8'hFF;
        run_conv("sar_ff", 1'b0, 400, cyc, res, prev);
        check("sar_ff_res", 32'(res), 32'hFF);
        stop();
        run_conv("ramp_ff", 1'b1, 6000, cyc, res, prev);
        check("ramp_ff_res", 32'(res), 32'hFF);
        check("ramp_ff_cyc", 32'(cyc), 32'(256 * S + 1));
        check("ramp_ff_hold", 32'(prev), 32'hFF);
        stop();

        // Comparator stuck low
        analog = 1'b0;
        comp_force = 1'b0;
        run_conv("sar_zero", 1'b0, 400, cyc, res, prev);
        check("sar_zero_res", 32'(res), 32'h00);
        check("sar_zero_cyc", 32'(cyc), 32'd129);
        stop();
        run_conv("ramp_zero", 1'b1, 400, cyc, res, prev);
        check("ramp_zero_res", 32'(res), 32'h00);
        check("ramp_zero_cyc", 32'(cyc), 32'(S + 1));
        stop();

        // algorithm_sel toggled mid-SAR only affects the next conversion
        analog = 1'b1;
        vin = 8'hDA;
        bus.enable = 1'b1;
        bus.algorithm_sel = 1'b0;
        repeat (40) tick();
        bus.algorithm_sel = 1'b1;
        wait_ready("toggle_sar", 400, cyc, res, prev, nlo);
        check("toggle_sar_res", 32'(res), 32'hDA);
        check("toggle_sar_cyc", 32'(cyc), 32'd90);
        wait_ready("toggle_ramp", 5000, cyc, res, prev, nlo);
        check("toggle_ramp_res", 32'(res), 32'hDA);
        check("toggle_ramp_cyc", 32'(cyc), 32'(220 * S + 1));
        stop();

        // enable dropped mid-conversion aborts without a result
        vin = 8'h10;
        bus.enable = 1'b1;
        bus.algorithm_sel = 1'b0;
        repeat (50) tick();
        check("abort_busy_before", 32'(bus.busy), 32'h1);
        bus.enable = 1'b0;
        tick();
        check("abort_r2r", 32'(bus.r2r_out), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        seen = 1'b0;
        repeat (200) begin
            if (bus.ready) seen = 1'b1;
            tick();
        end
        check("abort_noready", 32'(seen), 32'h0);
        check("abort_sample", 32'(bus.sample_out), 32'hDA);

        // Continuous SAR stream
        vin = 8'h33;
        run_conv("cont0", 1'b0, 400, cyc, res, prev);
        check("cont0_res", 32'(res), 32'h33);
        for (int i = 1; i < 5; i++) begin
            wait_ready($sformatf("cont%0d", i), 400, cyc, res, prev, nlo);
            check($sformatf("cont%0d_period", i), 32'(cyc), 32'd129);
            check($sformatf("cont%0d_res", i), 32'(res), 32'h33);
            check($sformatf("cont%0d_busylo", i), 32'(nlo), 32'd1);
        end
        stop();

        // Asynchronous reset during step 3 of a SAR conversion
        vin = 8'h5A;
        bus.enable = 1'b1;
        bus.algorithm_sel = 1'b0;
        repeat (3 * S + 5) tick();
        #1 reset = 1'b1;
        #1;
        check("mid_rst_r2r", 32'(bus.r2r_out), 32'h0);
        check("mid_rst_sample", 32'(bus.sample_out), 32'h0);
        check("mid_rst_ready", 32'(bus.ready), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'h1);
        check("post_rst_r2r", 32'(bus.r2r_out), 32'h80);
        wait_ready("post_rst", 400, cyc, res, prev, nlo);
        check("post_rst_res", 32'(res), 32'h5A);
        check("post_rst_cyc", 32'(cyc), 32'd129);
        stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
